multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB for R, addi, lw, sw, beq and j.
// Memory waits are bounded by TIMEOUT; any illegal opcode or memory
// timeout parks the unit in HALT with a sticky error flag.
// The opcode is never stored here: the IR holds it across the instruction.

module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  opcode_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        ir_write_o,
    output logic        iord_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        reg_write_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic [1:0]  pc_src_o,
    output logic [2:0]  state_o,
    output logic        instr_done_o,
    output logic [31:0] instr_cnt_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    // ALU source B selections
    localparam logic [1:0] SRC_B_RT    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_IMMSH = 2'b11;

    // ALU operation selections
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // PC source selections
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  wait_cnt_q;
    logic [7:0]  wait_cnt_d;
    logic [31:0] instr_cnt_q;
    logic        err_q;

    logic        is_r;
    logic        is_j;
    logic        is_beq;
    logic        is_addi;
    logic        is_lw;
    logic        is_sw;
    logic        wait_expired;

    assign is_r    = (opcode_i == OP_R);
    assign is_j    = (opcode_i == OP_J);
    assign is_beq  = (opcode_i == OP_BEQ);
    assign is_addi = (opcode_i == OP_ADDI);
    assign is_lw   = (opcode_i == OP_LW);
    assign is_sw   = (opcode_i == OP_SW);

    // A wait has run out once the counter reaches the limit with no ready
    assign wait_expired = !mem_ready_i && (wait_cnt_q >= TIMEOUT_CNT);

    assign state_o     = state_q;
    assign instr_cnt_o = instr_cnt_q;
    assign err_o       = err_q;

    // State register; reset forces FETCH without waiting for a clock edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection from current state, opcode and memory handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (mem_ready_i) begin
                    state_d = DECODE;
                end else if (wait_expired) begin
                    state_d = HALT;
                end
            end
            DECODE: begin
                if (is_r || is_addi || is_lw || is_sw || is_beq) begin
                    state_d = EXEC;
                end else if (is_j) begin
                    state_d = FETCH;
                end else begin
                    state_d = HALT;
                end
            end
            EXEC: begin
                if (is_r || is_addi) begin
                    state_d = WB;
                end else if (is_lw || is_sw) begin
                    state_d = MEM;
                end else if (is_beq) begin
                    state_d = FETCH;
                end else begin
                    state_d = HALT;
                end
            end
            MEM: begin
                if (mem_ready_i) begin
                    if (is_lw) begin
                        state_d = WB;
                    end else if (is_sw) begin
                        state_d = FETCH;
                    end else begin
                        state_d = HALT;
                    end
                end else if (wait_expired) begin
                    state_d = HALT;
                end
            end
            WB: begin
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // Wait counter advances only while stalled in FETCH/MEM; entering or ready clears it
    always_comb begin
        wait_cnt_d = 8'd0;
        if ((state_q == FETCH || state_q == MEM) && !mem_ready_i && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Bookkeeping registers: wait counter, retire count and sticky error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q  <= 8'd0;
            instr_cnt_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            if (instr_done_o) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
            if (state_d == HALT) begin
                err_q <= 1'b1;
            end
        end
    end

    // Control outputs decoded from the current state; all held low during reset
    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRC_B_RT;
        alu_op_o     = ALU_ADD;
        pc_src_o     = PC_ALU;
        instr_done_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                FETCH: begin
                    mem_read_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_write_o  = 1'b1;
                        pc_write_o  = 1'b1;
                        alu_src_b_o = SRC_B_FOUR;
                        alu_op_o    = ALU_ADD;
                        pc_src_o    = PC_ALU;
                    end
                end
                DECODE: begin
                    alu_src_b_o = SRC_B_IMMSH;
                    alu_op_o    = ALU_ADD;
                    if (is_j) begin
                        pc_write_o   = 1'b1;
                        pc_src_o     = PC_JUMP;
                        instr_done_o = 1'b1;
                    end
                end
                EXEC: begin
                    if (is_r) begin
                        alu_src_a_o = 1'b1;
                        alu_src_b_o = SRC_B_RT;
                        alu_op_o    = ALU_FUNCT;
                    end else if (is_addi || is_lw || is_sw) begin
                        alu_src_a_o = 1'b1;
                        alu_src_b_o = SRC_B_IMM;
                        alu_op_o    = ALU_ADD;
                    end else if (is_beq) begin
                        alu_src_a_o  = 1'b1;
                        alu_src_b_o  = SRC_B_RT;
                        alu_op_o     = ALU_SUB;
                        pc_src_o     = PC_ALUOUT;
                        pc_write_o   = zero_i;
                        instr_done_o = 1'b1;
                    end
                end
                MEM: begin
                    iord_o      = 1'b1;
                    mem_read_o  = is_lw;
                    mem_write_o = is_sw;
                    if (mem_ready_i && is_sw) begin
                        instr_done_o = 1'b1;
                    end
                end
                WB: begin
                    reg_write_o  = 1'b1;
                    instr_done_o = 1'b1;
                    reg_dst_o    = is_r;
                    mem_to_reg_o = is_lw;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
